// File: rtl/cla_multiword_sequencer.sv
// cla_multiword_sequencer
//   Runs a WIDTH-bit add/subtract through one shared 4-bit combinational CLA
//   slice, one nibble per cycle, LSB first. Each nibble's carry-out is held in
//   a register and fed back as the next nibble's carry-in.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a request; slice inputs held at 0
//   RUN   | nibble idx is driven to the slice and captured at each edge
//   DONE  | response valid; waits for rsp_ready
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_A, req_B              operands (WIDTH bits)
//   req_Cin, req_control      carry into nibble 0, 0 = add / 1 = subtract
//   slc_A, slc_B, slc_Cin,    nibble operands, carry and mode to the slice
//   slc_control
//   slc_sum, slc_Cout         slice result, sampled in the same cycle
//   rsp_valid/rsp_ready       response handshake
//   rsp_sum, rsp_Cout,        full-width result, final carry, signed overflow
//   rsp_ovf
module cla_multiword_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_A,
  input  logic [WIDTH-1:0] req_B,
  input  logic             req_Cin,
  input  logic             req_control,
  output logic [3:0]       slc_A,
  output logic [3:0]       slc_B,
  output logic             slc_Cin,
  output logic             slc_control,
  input  logic [3:0]       slc_sum,
  input  logic             slc_Cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_Cout,
  output logic             rsp_ovf
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             ctl_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_next;
  logic             running;

  assign running = (state == S_RUN);

  // Slice inputs come straight from registered state; B goes out uninverted,
  // the slice applies control itself.
  assign slc_A       = running ? a_q[{idx_q, 2'b00} +: 4] : 4'd0;
  assign slc_B       = running ? b_q[{idx_q, 2'b00} +: 4] : 4'd0;
  assign slc_Cin     = running & carry_q;
  assign slc_control = running & ctl_q;

  // Gated by rst so nothing is accepted while reset is held.
  assign req_ready = (state == S_IDLE) && !rst;

  // Result with the current nibble merged in; lets the final edge load the
  // response directly without waiting for result_q to settle.
  always_comb begin
    result_next = result_q;
    result_next[{idx_q, 2'b00} +: 4] = slc_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      ctl_q     <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      result_q  <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_Cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_q     <= req_A;
            b_q     <= req_B;
            ctl_q   <= req_control;
            carry_q <= req_Cin;
            idx_q   <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          result_q <= result_next;
          carry_q  <= slc_Cout;
          if (idx_q == LAST_IDX) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_sum   <= result_next;
            rsp_Cout  <= slc_Cout;
            // Overflow: operand signs agree (B as the slice sees it) and the
            // result sign differs.
            rsp_ovf   <= (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ ctl_q)) &&
                         (slc_sum[3] != a_q[WIDTH-1]);
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
module tb_cla_multiword_sequencer;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [W-1:0]  req_A, req_B;
  logic          req_Cin, req_control;
  logic [3:0]    slc_A, slc_B, slc_sum;
  logic          slc_Cin, slc_control, slc_Cout;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_sum;
  logic          rsp_Cout, rsp_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cla_multiword_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_Cin(req_Cin), .req_control(req_control),
    .slc_A(slc_A), .slc_B(slc_B), .slc_Cin(slc_Cin), .slc_control(slc_control),
    .slc_sum(slc_sum), .slc_Cout(slc_Cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_Cout(rsp_Cout), .rsp_ovf(rsp_ovf)
  );

  // The existing combinational 4-bit slice.
  logic [4:0] slc_full;
  assign slc_full = {1'b0, slc_A} + {1'b0, slc_B ^ {4{slc_control}}} + {4'd0, slc_Cin};
  assign slc_sum  = slc_full[3:0];
  assign slc_Cout = slc_full[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] full_add(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic ctl);
    return {1'b0, a} + {1'b0, b ^ {W{ctl}}} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic carry_into(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic ctl, int k);
    logic [31:0] m, t;
    if (k == 0) return cin;
    m = (32'd1 << (4 * k)) - 32'd1;
    t = ({16'd0, a} & m) + ({16'd0, b ^ {W{ctl}}} & m) + {31'd0, cin};
    return t[4 * k];
  endfunction

  // Reference model: m_since = -1 waiting for a request, 0..NIB-1 cycles into
  // the operation, NIB result presented.
  bit           m_on = 1'b0;
  int           m_since = -1;
  logic [W-1:0] m_a, m_b;
  logic         m_cin, m_ctl;
  logic [W-1:0] e_sum;
  logic         e_cout, e_ovf;

  always @(posedge clk) begin
    logic [W:0] f;
    if (rst) begin
      m_on    <= 1'b1;
      m_since <= -1;
      e_sum   <= '0;
      e_cout  <= 1'b0;
      e_ovf   <= 1'b0;
    end else if (m_on) begin
      if (m_since == -1) begin
        if (req_valid) begin
          m_a <= req_A; m_b <= req_B; m_cin <= req_Cin; m_ctl <= req_control;
          m_since <= 0;
        end
      end else if (m_since < NIB) begin
        m_since <= m_since + 1;
        if (m_since == NIB - 1) begin
          f = full_add(m_a, m_b, m_cin, m_ctl);
          e_sum  <= f[W-1:0];
          e_cout <= f[W];
          e_ovf  <= (m_a[W-1] == (m_b[W-1] ^ m_ctl)) && (f[W-1] != m_a[W-1]);
        end
      end else if (rsp_ready) begin
        m_since <= -1;
      end
    end
  end

  always @(negedge clk) begin
    bit run;
    int k;
    if (m_on) begin
      run = (m_since >= 0) && (m_since < NIB);
      k   = run ? m_since : 0;
      check("req_ready", req_ready, (!rst && m_since == -1));
      check("rsp_valid", rsp_valid, (m_since == NIB));
      check("rsp_sum", rsp_sum, e_sum);
      check("rsp_Cout", rsp_Cout, e_cout);
      check("rsp_ovf", rsp_ovf, e_ovf);
      check("slc_A", slc_A, run ? ((m_a >> (4 * k)) & 16'hF) : 32'd0);
      check("slc_B", slc_B, run ? ((m_b >> (4 * k)) & 16'hF) : 32'd0);
      check("slc_Cin", slc_Cin, run ? carry_into(m_a, m_b, m_cin, m_ctl, k) : 1'b0);
      check("slc_control", slc_control, run ? m_ctl : 1'b0);
    end
  end

  // Entered just after a rising edge. Returns the response plus how many
  // cycles the request waited, acceptance-to-valid latency, and the
  // per-nibble slc_Cin / slc_control seen during RUN.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic ctl,
                       input int hold, input bit keep,
                       input logic [W-1:0] na, input logic [W-1:0] nb, input logic ncin, input logic nctl,
                       output logic [W-1:0] s, output logic co, output logic ov,
                       output int waitn, output int lat, output logic [7:0] cinb, output logic [7:0] ctlb);
    req_valid = 1'b1; req_A = a; req_B = b; req_Cin = cin; req_control = ctl;
    rsp_ready = 1'b0;
    cinb = '0; ctlb = '0;
    waitn = 0;
    @(negedge clk);
    while (!req_ready && waitn < 50) begin @(negedge clk); waitn++; end
    if (waitn >= 50) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = keep; req_A = na; req_B = nb; req_Cin = ncin; req_control = nctl;
    @(negedge clk);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      if (lat < 8) begin cinb[lat] = slc_Cin; ctlb[lat] = slc_control; end
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) check("rsp_timeout", 32'd0, 32'd1);
    s = rsp_sum; co = rsp_Cout; ov = rsp_ovf;
    repeat (hold) @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  logic [W-1:0] s;
  logic         co, ov;
  int           waitn, lat;
  logic [7:0]   cinb, ctlb;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_A = '0; req_B = '0; req_Cin = 1'b0;
    req_control = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", req_ready, 1'b0);
    check("reset_rsp_sum", rsp_sum, 16'h0000);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_req_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;

    do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0, 1'b0, s, co, ov, waitn, lat, cinb, ctlb);
    check("add_sum", s, 16'h2201);
    check("add_cout", co, 1'b0);
    check("add_ovf", ov, 1'b0);
    check("add_latency", lat, 4);
    check("add_cin_seq", cinb[3:0], 4'b1110);

    do_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b0, 1'b0, s, co, ov, waitn, lat, cinb, ctlb);
    check("addc_sum", s, 16'h0001);
    check("addc_cout", co, 1'b1);
    check("addc_ovf", ov, 1'b0);

    do_op(16'h0006, 16'h000C, 1'b1, 1'b1, 0, 1'b0, '0, '0, 1'b0, 1'b0, s, co, ov, waitn, lat, cinb, ctlb);
    check("sub_sum", s, 16'hFFFA);
    check("sub_cout", co, 1'b0);
    check("sub_ovf", ov, 1'b0);
    check("sub_ctl_seq", ctlb[3:0], 4'b1111);

    do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0, 1'b0, '0, '0, 1'b0, 1'b0, s, co, ov, waitn, lat, cinb, ctlb);
    check("subov_sum", s, 16'h7FFF);
    check("subov_cout", co, 1'b1);
    check("subov_ovf", ov, 1'b1);

    // Backpressure with a second request held valid throughout.
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 5, 1'b1, 16'h00F0, 16'h0F10, 1'b0, 1'b0,
          s, co, ov, waitn, lat, cinb, ctlb);
    check("bp_sum", s, 16'h3333);
    do_op(16'h00F0, 16'h0F10, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0, 1'b0, s, co, ov, waitn, lat, cinb, ctlb);
    check("bp_second_wait", waitn, 0);
    check("bp_second_sum", s, 16'h1000);

    // Reset abort after two nibbles.
    req_valid = 1'b1; req_A = 16'h1234; req_B = 16'h0FCD; req_Cin = 1'b0; req_control = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_slc_A", slc_A, 4'd0);
    check("abort_req_ready", req_ready, 1'b1);
    repeat (6) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    do_op(16'h0003, 16'h0005, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0, 1'b0, s, co, ov, waitn, lat, cinb, ctlb);
    check("after_abort_sum", s, 16'h0008);

    // Randomized traffic; the reference model checks every cycle.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      req_valid   = 1'($urandom_range(0, 1));
      req_A       = 16'($urandom);
      req_B       = 16'($urandom);
      req_Cin     = 1'($urandom_range(0, 1));
      req_control = 1'($urandom_range(0, 1));
      rsp_ready   = ($urandom_range(0, 3) != 0);
      rst         = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk);
    #1 rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
